// File: rtl/led_pwm_fade.sv
// Breathing/fade generator: ramps the PWM duty value between configurable limits
// with holds at each end, feeding the duty-cycle input of the LED PWM core.
module led_pwm_fade #(
    parameter int counter_width_p   = 8,
    parameter int prescaler_width_p = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cr_enable,
    input  logic [counter_width_p-1:0]   cr_duty_min,
    input  logic [counter_width_p-1:0]   cr_duty_max,
    input  logic [counter_width_p-1:0]   cr_step,
    input  logic [prescaler_width_p-1:0] cr_step_period,
    input  logic [prescaler_width_p-1:0] cr_hold_ticks,
    output logic [counter_width_p-1:0]   pwm_duty,
    output logic                         fade_active,
    output logic                         fade_cycle_done
);

    localparam logic [prescaler_width_p-1:0] pre_zero_lp = '0;
    localparam logic [prescaler_width_p-1:0] pre_one_lp  = {{(prescaler_width_p-1){1'b0}}, 1'b1};
    localparam logic [counter_width_p-1:0]   duty_one_lp = {{(counter_width_p-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        UP,
        HOLD_HI,
        DOWN,
        HOLD_LO
    } state_t;

    state_t state_q, state_d;

    logic [counter_width_p-1:0]   min_q, max_q, step_q, duty_q;
    logic [prescaler_width_p-1:0] period_q, hold_q, prescaler_q, hold_cnt_q;
    logic                         done_q;

    logic                         start;
    logic                         tick;
    logic                         hold_last;
    logic [prescaler_width_p-1:0] hold_cnt_inc;
    logic [counter_width_p:0]     sum_up, floor_dn;
    logic [counter_width_p-1:0]   up_val, dn_val;

    assign start        = (state_q == IDLE) && cr_enable;
    assign tick         = (state_q != IDLE) && (prescaler_q == period_q - pre_one_lp);
    assign hold_cnt_inc = hold_cnt_q + pre_one_lp;
    assign hold_last    = (hold_q == pre_zero_lp) || (tick && (hold_cnt_inc == hold_q));

    // Ramp arithmetic is one bit wider so the step can never wrap past either limit.
    assign sum_up   = {1'b0, duty_q} + {1'b0, step_q};
    assign floor_dn = {1'b0, min_q} + {1'b0, step_q};
    assign up_val   = (sum_up >= {1'b0, max_q}) ? max_q : sum_up[counter_width_p-1:0];
    assign dn_val   = ({1'b0, duty_q} >= floor_dn) ? (duty_q - step_q) : min_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Disable wins over every other transition, including one due on this tick.
    always_comb begin
        state_d = state_q;
        if ((state_q != IDLE) && !cr_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cr_enable) state_d = UP;
                UP:      if (tick && (up_val == max_q)) state_d = HOLD_HI;
                HOLD_HI: if (hold_last) state_d = DOWN;
                DOWN:    if (tick && (dn_val == min_q)) state_d = HOLD_LO;
                HOLD_LO: if (hold_last) state_d = UP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pwm_duty        = duty_q;
        fade_active     = (state_q != IDLE);
        fade_cycle_done = done_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_q       <= '0;
            max_q       <= '0;
            step_q      <= '0;
            period_q    <= '0;
            hold_q      <= '0;
            prescaler_q <= '0;
            hold_cnt_q  <= '0;
            duty_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == HOLD_LO) && (state_d == UP);

            if (start) begin
                min_q    <= cr_duty_min;
                max_q    <= (cr_duty_min > cr_duty_max) ? cr_duty_min : cr_duty_max;
                step_q   <= (cr_step == '0) ? duty_one_lp : cr_step;
                period_q <= (cr_step_period == pre_zero_lp) ? pre_one_lp : cr_step_period;
                hold_q   <= cr_hold_ticks;
            end

            if ((state_q == IDLE) || (state_d == IDLE) || tick) begin
                prescaler_q <= '0;
            end else begin
                prescaler_q <= prescaler_q + pre_one_lp;
            end

            if (state_d != state_q) begin
                hold_cnt_q <= '0;
            end else if (((state_q == HOLD_HI) || (state_q == HOLD_LO)) && tick) begin
                hold_cnt_q <= hold_cnt_inc;
            end

            if (state_d == IDLE) begin
                duty_q <= '0;
            end else if (state_q == IDLE) begin
                duty_q <= cr_duty_min;
            end else if ((state_q == UP) && tick) begin
                duty_q <= up_val;
            end else if ((state_q == DOWN) && tick) begin
                duty_q <= dn_val;
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_fade.sv
// Self-checking bench for led_pwm_fade: per-cycle scoreboard against a behavioural
// model, plus hand-derived duty tables for the ramp, saturation and corner cases.
module tb_led_pwm_fade;

    localparam int CW = 8;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cr_enable;
    logic [CW-1:0] cr_duty_min, cr_duty_max, cr_step;
    logic [PW-1:0] cr_step_period, cr_hold_ticks;
    logic [CW-1:0] pwm_duty;
    logic          fade_active, fade_cycle_done;

    int checks   = 0;
    int failures = 0;

    led_pwm_fade #(.counter_width_p(CW), .prescaler_width_p(PW)) dut (
        .clk             (clk),
        .rst             (rst),
        .cr_enable       (cr_enable),
        .cr_duty_min     (cr_duty_min),
        .cr_duty_max     (cr_duty_max),
        .cr_step         (cr_step),
        .cr_step_period  (cr_step_period),
        .cr_hold_ticks   (cr_hold_ticks),
        .pwm_duty        (pwm_duty),
        .fade_active     (fade_active),
        .fade_cycle_done (fade_cycle_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] duty;
        logic          active;
        logic          done;
    } obs_t;

    typedef struct {
        int edge_n;
        int duty;
        int active;
        int done;
    } vec_t;

    obs_t exp_q[$];

    // Behavioural reference: 0 idle, 1 up, 2 hold-high, 3 down, 4 hold-low.
    int ms = 0, md = 0, mdone = 0, mpre = 0, mh = 0;
    int lo = 0, hi = 0, st = 1, per = 1, hd = 0;

    int cyc = 0;
    int hist_duty[0:127];
    int hist_done[0:127];
    int hist_act[0:127];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic model_edge();
        bit t;
        mdone = 0;
        if (rst) begin
            ms = 0; md = 0; mpre = 0; mh = 0;
            return;
        end
        if (ms == 0) begin
            if (cr_enable) begin
                lo  = cr_duty_min;
                hi  = (cr_duty_max < cr_duty_min) ? cr_duty_min : cr_duty_max;
                st  = (cr_step == 0) ? 1 : cr_step;
                per = (cr_step_period == 0) ? 1 : cr_step_period;
                hd  = cr_hold_ticks;
                ms  = 1; md = lo; mpre = 0; mh = 0;
            end
            return;
        end
        if (!cr_enable) begin
            ms = 0; md = 0; mpre = 0; mh = 0;
            return;
        end
        t = (mpre == per - 1);
        mpre = t ? 0 : mpre + 1;
        case (ms)
            1: if (t) begin
                md = (md + st > hi) ? hi : md + st;
                if (md == hi) begin ms = 2; mh = 0; end
            end
            3: if (t) begin
                md = (md - st < lo) ? lo : md - st;
                if (md == lo) begin ms = 4; mh = 0; end
            end
            default: begin
                if (hd == 0) mh = hd;
                else if (t) mh++;
                if (mh == hd && (hd == 0 || t)) begin
                    if (ms == 4) begin ms = 1; mdone = 1; end
                    else ms = 3;
                    mh = 0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input int n);
        obs_t e, a;
        for (int i = 0; i < n; i++) begin
            model_edge();
            e.duty   = md[CW-1:0];
            e.active = (ms != 0);
            e.done   = mdone[0];
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            a = {pwm_duty, fade_active, fade_cycle_done};
            e = exp_q.pop_front();
            checkOutput("scoreboard", a, e);
            cyc++;
            if (cyc < 128) begin
                hist_duty[cyc] = pwm_duty;
                hist_done[cyc] = fade_cycle_done;
                hist_act[cyc]  = fade_active;
            end
        end
    endtask

    task automatic set_cfg(input int mn, input int mx, input int sp, input int pd, input int hl);
        cr_duty_min    = mn[CW-1:0];
        cr_duty_max    = mx[CW-1:0];
        cr_step        = sp[CW-1:0];
        cr_step_period = pd[PW-1:0];
        cr_hold_ticks  = hl[PW-1:0];
    endtask

    task automatic restart();
        cr_enable = 1'b0;
        applyStimulus(1);
        cr_enable = 1'b1;
        cyc = 0;
    endtask

    vec_t ramp_tbl[15];
    int   sat_tbl[8];
    int   cnt;

    initial begin
        ramp_tbl = '{
            '{1, 10, 1, 0}, '{4, 10, 1, 0}, '{5, 20, 1, 0}, '{9, 30, 1, 0},
            '{13, 40, 1, 0}, '{17, 50, 1, 0}, '{24, 50, 1, 0}, '{28, 50, 1, 0},
            '{29, 40, 1, 0}, '{41, 10, 1, 0}, '{48, 10, 1, 0}, '{49, 10, 1, 1},
            '{50, 10, 1, 0}, '{52, 10, 1, 0}, '{53, 20, 1, 0}
        };
        sat_tbl = '{0, 100, 200, 255, 255, 155, 55, 0};

        rst = 1'b1;
        cr_enable = 1'b1;
        set_cfg(10, 50, 10, 4, 2);
        applyStimulus(3);
        checkOutput("reset_duty", pwm_duty, 0);
        checkOutput("reset_active", fade_active, 0);
        rst = 1'b0;
        cr_enable = 1'b0;
        applyStimulus(4);
        checkOutput("idle_duty", pwm_duty, 0);
        checkOutput("idle_active", fade_active, 0);

        // Basic ramp up, hold, ramp down, hold, back to up
        cr_enable = 1'b1;
        cyc = 0;
        applyStimulus(55);
        foreach (ramp_tbl[k]) begin
            checkOutput($sformatf("ramp_duty@%0d", ramp_tbl[k].edge_n), hist_duty[ramp_tbl[k].edge_n], ramp_tbl[k].duty);
            checkOutput($sformatf("ramp_act@%0d", ramp_tbl[k].edge_n), hist_act[ramp_tbl[k].edge_n], ramp_tbl[k].active);
            checkOutput($sformatf("ramp_done@%0d", ramp_tbl[k].edge_n), hist_done[ramp_tbl[k].edge_n], ramp_tbl[k].done);
        end
        cnt = 0;
        for (int k = 1; k <= 52; k++) cnt += hist_done[k];
        checkOutput("ramp_done_count", cnt, 1);

        // Disable on a DOWN tick, then re-enable with a new config
        restart();
        set_cfg(10, 50, 10, 4, 2);
        applyStimulus(28);
        cr_enable = 1'b0;
        applyStimulus(1);
        checkOutput("disable_duty", pwm_duty, 0);
        checkOutput("disable_active", fade_active, 0);
        checkOutput("disable_done", fade_cycle_done, 0);
        set_cfg(5, 15, 5, 2, 0);
        cr_enable = 1'b1;
        cyc = 0;
        applyStimulus(3);
        checkOutput("reenable_first", hist_duty[1], 5);
        checkOutput("reenable_step", hist_duty[3], 10);

        // Config change mid-fade is ignored until the next enable
        restart();
        set_cfg(10, 50, 10, 4, 2);
        applyStimulus(2);
        cr_step = 8'd20;
        applyStimulus(4);
        checkOutput("old_step_kept", hist_duty[5], 20);
        restart();
        applyStimulus(5);
        checkOutput("new_step_used", hist_duty[5], 30);

        // Saturation at both rails
        restart();
        set_cfg(0, 255, 100, 1, 0);
        applyStimulus(10);
        foreach (sat_tbl[k]) checkOutput($sformatf("sat_duty@%0d", k + 1), hist_duty[k + 1], sat_tbl[k]);
        checkOutput("sat_done", hist_done[9], 1);

        // Degenerate: zero step/period, min == max
        restart();
        set_cfg(30, 30, 0, 0, 1);
        applyStimulus(20);
        cnt = 0;
        for (int k = 1; k <= 20; k++) if (hist_duty[k] != 30) cnt++;
        checkOutput("degen_const", cnt, 0);
        cnt = 0;
        for (int k = 1; k <= 20; k++) cnt += hist_done[k];
        checkOutput("degen_done_count", cnt, 4);

        // Inverted limits clamp max up to min
        restart();
        set_cfg(60, 20, 5, 1, 0);
        applyStimulus(12);
        cnt = 0;
        for (int k = 1; k <= 12; k++) if (hist_duty[k] != 60) cnt++;
        checkOutput("inverted_const", cnt, 0);

        // Reset asserted mid-fade
        rst = 1'b1;
        applyStimulus(1);
        checkOutput("midreset_duty", pwm_duty, 0);
        checkOutput("midreset_active", fade_active, 0);
        rst = 1'b0;
        cr_enable = 1'b0;
        applyStimulus(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_fade.md
Name: led_pwm_fade

Overview:
- Breathing/fade generator that sits directly upstream of the LED PWM core and drives its duty-cycle input.
- Ramps the duty value up from a minimum to a maximum, holds it, ramps it back down, holds it, and repeats while enabled.
- Step size, step interval, hold time and limits all come from configuration registers.

Parameters:
- counter_width_p, 8: width of the duty value; must equal the PWM core counter width.
- prescaler_width_p, 16: width of the step-interval and hold counters.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- cr_enable  input  1  fade enable, level-sensitive
- cr_duty_min  input  counter_width_p  lower duty limit
- cr_duty_max  input  counter_width_p  upper duty limit
- cr_step  input  counter_width_p  duty increment/decrement per tick
- cr_step_period  input  prescaler_width_p  clk cycles per tick
- cr_hold_ticks  input  prescaler_width_p  ticks spent at each limit
- pwm_duty  output  counter_width_p  duty value, feeds the PWM core cr_pwm_duty
- fade_active  output  1  high in any non-IDLE state
- fade_cycle_done  output  1  one-cycle pulse at the end of each full up/hold/down/hold cycle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state IDLE, pwm_duty 0, fade_active 0, fade_cycle_done 0, prescaler 0, hold counter 0. A reset asserted mid-fade returns the block to these values on the next edge.
- States: IDLE, UP, HOLD_HI, DOWN, HOLD_LO.
- Config latch: on leaving IDLE, all cr_* values are latched into shadow registers. Later cr_* changes take effect only after the next return to IDLE.
- Normalisation at latch time:
  - step 0 is treated as 1.
  - step_period 0 is treated as 1.
  - if min > max, max is set to min.
- Tick generator:
  - Prescaler counts 0..period-1 in every non-IDLE state and is cleared on leaving IDLE.
  - tick is asserted for one cycle when prescaler == period-1.
- IDLE -> UP: when cr_enable=1. Next cycle: pwm_duty = min, fade_active = 1.
- UP:
  - On tick: pwm_duty = min(pwm_duty + step, max), computed at counter_width_p+1 bits so it never wraps.
  - On the tick where the result equals max, go to HOLD_HI; the hold counter is cleared.
  - If min == max, go to HOLD_HI on the first tick with pwm_duty unchanged.
- HOLD_HI:
  - Hold counter increments on each tick.
  - When the count reaches hold_ticks, go to DOWN.
  - hold_ticks = 0: leave on the first cycle in the state, without waiting for a tick.
- DOWN:
  - On tick: pwm_duty = max(pwm_duty - step, min), saturating and never underflowing.
  - When the result equals min, go to HOLD_LO.
- HOLD_LO:
  - Same hold rules as HOLD_HI.
  - On exit, fade_cycle_done pulses for exactly one cycle and the state goes to UP.
  - pwm_duty stays at min; the first increment occurs on the next tick.
- Disable: cr_enable=0 in any non-IDLE state forces IDLE on the next edge (pwm_duty 0, fade_active 0, no done pulse). This takes priority over a simultaneous tick or transition.
- Output timing: pwm_duty changes only on clock edges and is registered; there are no combinational paths from cr_* to outputs.
- Glitch-free update at PWM period boundaries is the PWM core's concern; this block may update pwm_duty on any cycle.

Test Plan:
- Reset/idle: rst=1 for 3 cycles with cr_enable=1 -> pwm_duty=0, fade_active=0. Release with cr_enable=0 -> state stays IDLE, outputs stay 0.
- Basic ramp: min=10, max=50, step=10, period=4, hold=2, enable -> pwm_duty = 10,20,30,40,50 at 4-cycle spacing; holds 50 for 8 cycles; steps down 40..10; holds 10 for 8 cycles; fade_cycle_done pulses once, one cycle wide.
- Saturation: min=0, max=255, step=100, period=1, hold=0 -> sequence 0,100,200,255,155,55,0. No wrap past 255 or below 0.
- Degenerate config: step=0, period=0, min=max=30, hold=1 -> pwm_duty constant 30; fade_cycle_done pulses periodically. min=60/max=20 -> pwm_duty constant 60.
- Disable mid-ramp: drop cr_enable during DOWN at a tick cycle -> next cycle IDLE, pwm_duty=0, no done pulse. Re-enable -> restarts at min with freshly latched config.
- Config change mid-fade: change cr_step 10->20 during UP -> step stays 10 until disable and re-enable, then 20 applies.
